// File: rtl/xgmii_xconnect.sv
// -----------------------------------------------------------------------------
// xgmii_xconnect
//   N-port XGMII cross-connect. Every output port picks any input port as its
//   source. Source changes are only honoured on frame boundaries, so an output
//   never carries a spliced or partial frame.
//
//   Per-output FSM:
//     state | meaning
//     SYNC  | emit IDLE, track cfg_sel, wait for a Start on the selected source
//     PASS  | forward the latched source word by word until End or truncation
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   rx_d      : per input port p, rx_d[p*72+:72] = {rxc[7:0], rxd[63:0]}
//   link_up   : per-port PHY link status
//   cfg_sel   : requested source per output (SEL_W bits each)
//   cfg_en    : per-output forwarding enable
//   tx_d      : per-output {txc, txd}, registered, one clock after its rx word
//   act_sel   : source currently latched per output
//   tx_frames : frames fully forwarded per output (saturating)
//   tx_trunc  : frames truncated per output (saturating)
//
// Build option:
//   XCONNECT_STATS_EN - when defined, tx_frames/tx_trunc count; otherwise both
//   read 0 and the counter logic is absent. Forwarding is identical either way.
// -----------------------------------------------------------------------------
module xgmii_xconnect #(
  parameter int NPORTS = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [NPORTS*72-1:0]    rx_d,
  input  logic [NPORTS-1:0]       link_up,
  input  logic [NPORTS*SEL_W-1:0] cfg_sel,
  input  logic [NPORTS-1:0]       cfg_en,
  output logic [NPORTS*72-1:0]    tx_d,
  output logic [NPORTS*SEL_W-1:0] act_sel,
  output logic [NPORTS*CNT_W-1:0] tx_frames,
  output logic [NPORTS*CNT_W-1:0] tx_trunc
);

  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  typedef enum logic {ST_SYNC, ST_PASS} state_e;

  function automatic logic is_start0(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic logic is_start4(input logic [71:0] w);
    return w[68] && (w[39:32] == 8'hFB);
  endfunction

  // One bit per lane holding a terminate or error control character.
  function automatic logic [7:0] end_lanes(input logic [71:0] w);
    logic [7:0] e;
    for (int l = 0; l < 8; l++) begin
      e[l] = w[64+l] && ((w[l*8 +: 8] == 8'hFD) || (w[l*8 +: 8] == 8'hFE));
    end
    return e;
  endfunction

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    state_e            st_q;
    logic [71:0]       tx_q;
    logic [SEL_W-1:0]  act_q;

    logic [SEL_W-1:0]  req_sel;
    logic [SEL_W-1:0]  src;
    logic [71:0]       src_w;
    logic              src_ok;
    logic              src_link;
    logic [7:0]        ends;
    logic              end_hit;
    logic              chain4;
    logic              link_ok;
    logic              trunc_hit;
    logic              take;
    logic              stay;

    always_comb begin
      req_sel  = cfg_sel[o*SEL_W +: SEL_W];
      // Once a frame is in flight the latched source is used, never cfg_sel.
      src      = (st_q == ST_PASS) ? act_q : req_sel;
      src_w    = IDLE_W;
      src_ok   = 1'b0;
      src_link = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        if (src == SEL_W'(p)) begin
          src_w    = rx_d[p*72 +: 72];
          src_link = link_up[p];
          src_ok   = 1'b1;
        end
      end
      ends      = end_lanes(src_w);
      end_hit   = |ends;
      // A lane-4 Start following an End in lanes 0-3: back-to-back frame.
      chain4    = (|ends[3:0]) && is_start4(src_w);
      link_ok   = src_ok && src_link && link_up[o] && cfg_en[o];
      trunc_hit = (st_q == ST_PASS) && !link_ok;
      take      = (st_q == ST_SYNC) && link_ok && (is_start0(src_w) || is_start4(src_w));
      stay      = chain4 && (req_sel == act_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        st_q  <= ST_SYNC;
        tx_q  <= IDLE_W;
        act_q <= '0;
      end else begin
        case (st_q)
          ST_SYNC: begin
            act_q <= req_sel;
            if (take) begin
              st_q <= ST_PASS;
              if (is_start0(src_w)) begin
                tx_q <= src_w;
              end else begin
                tx_q <= {src_w[71:68], 4'hF, src_w[63:32], 32'h07070707};
              end
            end else begin
              tx_q <= IDLE_W;
            end
          end
          ST_PASS: begin
            if (trunc_hit) begin
              st_q <= ST_SYNC;
              tx_q <= ERR_W;
            end else if (end_hit && !stay) begin
              st_q <= ST_SYNC;
              // Drop the start of a following frame we are not going to carry.
              if (chain4) begin
                tx_q <= {4'hF, src_w[67:64], 32'h07070707, src_w[31:0]};
              end else begin
                tx_q <= src_w;
              end
            end else begin
              tx_q <= src_w;
            end
          end
        endcase
      end
    end

    assign tx_d[o*72 +: 72]        = tx_q;
    assign act_sel[o*SEL_W +: SEL_W] = act_q;

`ifdef XCONNECT_STATS_EN
    logic [CNT_W-1:0] frm_q;
    logic [CNT_W-1:0] trc_q;
    logic             frame_done;

    assign frame_done = (st_q == ST_PASS) && !trunc_hit && end_hit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        frm_q <= '0;
        trc_q <= '0;
      end else begin
        if (frame_done && !(&frm_q)) frm_q <= frm_q + CNT_W'(1);
        if (trunc_hit && !(&trc_q))  trc_q <= trc_q + CNT_W'(1);
      end
    end

    assign tx_frames[o*CNT_W +: CNT_W] = frm_q;
    assign tx_trunc[o*CNT_W +: CNT_W]  = trc_q;
`else
    assign tx_frames[o*CNT_W +: CNT_W] = '0;
    assign tx_trunc[o*CNT_W +: CNT_W]  = '0;
`endif
  end

endmodule

// File: tb/tb_xgmii_xconnect.sv
module tb_xgmii_xconnect;
  localparam int NP = 4;
  localparam int SW = 2;
  localparam int CW = 32;
  localparam int TL = 48;
  localparam logic [71:0] IDLE = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERRW = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [NP*72-1:0]     rx_d;
  logic [NP-1:0]        link_up;
  logic [NP*SW-1:0]     cfg_sel;
  logic [NP-1:0]        cfg_en;
  logic [NP*72-1:0]     tx_d;
  logic [NP*SW-1:0]     act_sel;
  logic [NP*CW-1:0]     tx_frames;
  logic [NP*CW-1:0]     tx_trunc;

  xgmii_xconnect #(.NPORTS(NP), .SEL_W(SW), .CNT_W(CW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_d      (rx_d),
    .link_up   (link_up),
    .cfg_sel   (cfg_sel),
    .cfg_en    (cfg_en),
    .tx_d      (tx_d),
    .act_sel   (act_sel),
    .tx_frames (tx_frames),
    .tx_trunc  (tx_trunc)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string            tag;
    int               t;
    logic [NP*72-1:0] tx;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [71:0] rxs [NP][TL];
  logic [71:0] exs [NP][TL];
  logic [7:0]  cfgs [TL];
  logic [3:0]  lnks [TL];
  logic [3:0]  ens  [TL];
  int          ef [NP];
  int          et [NP];

  // Monitor: one expected word set per clock the stimulus has issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int o = 0; o < NP; o++) begin
          n_tests++;
          if (tx_d[o*72 +: 72] !== e.tx[o*72 +: 72]) begin
            n_fail++;
            $display("FAIL tx%0d %s t=%0d got=%h exp=%h", o, e.tag, e.t,
                     tx_d[o*72 +: 72], e.tx[o*72 +: 72]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [287:0] got, input logic [287:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [NP*CW-1:0] fexp;
    logic [NP*CW-1:0] texp;
    fexp = '0;
    texp = '0;
`ifdef XCONNECT_STATS_EN
    for (int o = 0; o < NP; o++) begin
      fexp[o*CW +: CW] = CW'(ef[o]);
      texp[o*CW +: CW] = CW'(et[o]);
    end
`endif
    chk({tag, " tx_frames"}, 288'(tx_frames), 288'(fexp));
    chk({tag, " tx_trunc"}, 288'(tx_trunc), 288'(texp));
  endtask

  task automatic clear(input logic [7:0] cfg);
    for (int t = 0; t < TL; t++) begin
      for (int p = 0; p < NP; p++) begin
        rxs[p][t] = IDLE;
        exs[p][t] = IDLE;
      end
      cfgs[t] = cfg;
      lnks[t] = 4'hF;
      ens[t]  = 4'hF;
    end
  endtask

  // 64-byte frame: Start+preamble word, 8 data words, terminate word.
  task automatic frame(input int p, input int t0, input int seed);
    rxs[p][t0] = {8'h01, 64'hD5555555555555FB};
    for (int k = 1; k <= 8; k++) begin
      rxs[p][t0+k] = {8'h00, 32'(seed), 32'(k) ^ 32'h5A5A0000};
    end
    rxs[p][t0+9] = {8'hFF, 64'h07070707070707FD};
  endtask

  task automatic cp(input int o, input int p, input int a, input int b);
    for (int t = a; t <= b; t++) exs[o][t] = rxs[p][t];
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    int   k;
    for (int t = 0; t < n; t++) begin
      @(negedge sys_clk);
      for (int p = 0; p < NP; p++) rx_d[p*72 +: 72] = rxs[p][t];
      cfg_sel = cfgs[t];
      link_up = lnks[t];
      cfg_en  = ens[t];
      e.tag = tag;
      e.t   = t;
      for (int o = 0; o < NP; o++) e.tx[o*72 +: 72] = exs[o][t];
      sbq.push_back(e);
    end
    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain %s got=%0d exp=0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [71:0] chain_w;
    logic [71:0] sfd_w;
    for (int o = 0; o < NP; o++) begin
      ef[o] = 0;
      et[o] = 0;
    end
    sys_rst_n = 1'b0;
    rx_d      = {NP{IDLE}};
    link_up   = 4'hF;
    cfg_en    = 4'hF;
    cfg_sel   = 8'hB1;
    repeat (3) @(negedge sys_clk);
    chk("reset tx_d", 288'(tx_d), 288'({NP{IDLE}}));
    chk("reset act_sel", 288'(act_sel), 288'(8'h00));
    chk_cnt("reset");
    sys_rst_n = 1'b1;

    // A: swapped selection {1,0,3,2}; rx0 frame lands on tx1 only.
    clear(8'hB1);
    frame(0, 2, 32'h11110000);
    cp(1, 0, 2, 11);
    run(16, "swap");
    ef[1] = 1;
    chk_cnt("swap");
    chk("swap act_sel", 288'(act_sel), 288'(8'hB1));

    // B: tx0 re-pointed to rx2 mid-frame; rx2 already inside a frame.
    clear(8'hE4);
    for (int t = 5; t < TL; t++) cfgs[t] = 8'hE6;
    frame(0, 2, 32'h22220000);
    frame(2, 7, 32'h33330000);
    frame(2, 20, 32'h44440000);
    cp(0, 0, 2, 11);
    cp(0, 2, 20, 29);
    cp(2, 2, 7, 16);
    cp(2, 2, 20, 29);
    run(34, "resel");
    ef[0] = 2;
    ef[2] = 2;
    chk_cnt("resel");
    chk("resel act_sel", 288'(act_sel), 288'(8'hE6));

    // C: back-to-back frames on rx3, second starting in lane 4 of the end word.
    clear(8'hF4);
    for (int t = 10; t < TL; t++) cfgs[t] = 8'hEC;
    rxs[3][2] = {8'h01, 64'hD5555555555555FB};
    for (int k = 3; k <= 9; k++) rxs[3][k] = {8'h00, 32'h55660000, 32'(k)};
    chain_w = {8'h1C, 64'h555555FB07FD2211};
    sfd_w   = {8'h00, 64'hDDCCBBAA99D55555};
    rxs[3][10] = chain_w;
    rxs[3][11] = sfd_w;
    for (int k = 12; k <= 18; k++) rxs[3][k] = {8'h00, 32'h77880000, 32'(k)};
    rxs[3][19] = {8'hFF, 64'h07070707070707FD};
    cp(3, 3, 2, 19);
    cp(2, 3, 2, 9);
    exs[2][10] = {8'hFC, 32'h07070707, 32'h07FD2211};
    exs[1][10] = {8'h1F, 32'h555555FB, 32'h07070707};
    cp(1, 3, 11, 19);
    run(24, "chain");
    ef[1] = 2;
    ef[2] = 3;
    ef[3] = 2;
    chk_cnt("chain");
    chk("chain act_sel", 288'(act_sel), 288'(8'hEC));

    // D: link_up[0] drops under tx1, cfg_en[3] drops under tx3.
    clear(8'hB1);
    for (int t = 5; t <= 13; t++) lnks[t] = 4'hE;
    for (int t = 7; t <= 13; t++) ens[t] = 4'h7;
    frame(0, 2, 32'h99990000);
    frame(2, 2, 32'hAAAA0000);
    cp(1, 0, 2, 4);
    exs[1][5] = ERRW;
    cp(3, 2, 2, 6);
    exs[3][7] = ERRW;
    run(18, "trunc");
    et[1] = 1;
    et[3] = 1;
    chk_cnt("trunc");

    // E: every output mirrors rx0.
    clear(8'h00);
    frame(0, 2, 32'hBBBB0000);
    for (int o = 0; o < NP; o++) cp(o, 0, 2, 11);
    run(16, "mirror");
    for (int o = 0; o < NP; o++) ef[o] = ef[o] + 1;
    chk_cnt("mirror");

    // F: reset asserted mid-frame clears tx_d without waiting for a clock.
    @(negedge sys_clk);
    rx_d[71:0] = {8'h01, 64'hD5555555555555FB};
    @(negedge sys_clk);
    rx_d[71:0] = {8'h00, 64'h0123456789ABCDEF};
    chk("midrst pre tx_d", 288'(tx_d), 288'({NP{72'({8'h01, 64'hD5555555555555FB})}}));
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst tx_d", 288'(tx_d), 288'({NP{IDLE}}));
    for (int o = 0; o < NP; o++) begin
      ef[o] = 0;
      et[o] = 0;
    end
    chk_cnt("midrst");
    rx_d = {NP{IDLE}};
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("post rst tx_d", 288'(tx_d), 288'({NP{IDLE}}));
    chk_cnt("post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
